// File: rtl/clk_div_pkg.sv
// Shared types for the run-time clock divider controller.
package clk_div_pkg;

  typedef enum logic [1:0] {STOP, RUN, PEND, STOPPING} clkdiv_state_t;

  localparam int CLKDIV_CNT_WIDTH = 32;

endpackage

// File: rtl/clk_div_core.sv
// Divider datapath: half-period register, phase counter, clk_out toggle flop and tick pulses.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEF_HALF = 2
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] load_half,
  output logic             clk_out,
  output logic             tick_rise,
  output logic             tick_fall,
  output logic             last
);

  logic [CNT_W-1:0] half_q, half_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  assign last = (cnt_q == half_q - CNT_W'(1));

  always_comb begin
    half_d = load ? load_half : half_q;
    cnt_d  = cnt_q;
    clk_d  = clk_q;
    rise_d = 1'b0;
    fall_d = 1'b0;
    if (!en) begin
      // Parked: counter cleared, clock held low, ready for a clean first phase.
      cnt_d = '0;
      clk_d = 1'b0;
    end else if (last) begin
      cnt_d  = '0;
      clk_d  = ~clk_q;
      rise_d = ~clk_q;
      fall_d = clk_q;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    if (load) cnt_d = '0;
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      half_q <= CNT_W'(DEF_HALF);
      cnt_q  <= '0;
      clk_q  <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      half_q <= half_d;
      cnt_q  <= cnt_d;
      clk_q  <= clk_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  assign clk_out   = clk_q;
  assign tick_rise = rise_q;
  assign tick_fall = fall_q;

endmodule

// File: rtl/clk_div_sched.sv
// Clock divider scheduler: run/stop FSM and cfg handshake; half-period changes land only at a
// falling toggle. Define CLKDIV_CNT_EN to add the rise_cnt output.
module clk_div_sched
  import clk_div_pkg::*;
#(
  parameter int CNT_W    = 8,
  parameter int DEF_HALF = 2
) (
  input  logic                        clk_in,
  input  logic                        reset,
  input  logic                        run,
  input  logic                        cfg_valid,
  input  logic [CNT_W-1:0]            cfg_half,
  output logic                        cfg_ready,
  output logic                        cfg_err,
  output logic                        clk_out,
  output logic                        tick_rise,
  output logic                        tick_fall,
`ifdef CLKDIV_CNT_EN
  output logic [CLKDIV_CNT_WIDTH-1:0] rise_cnt,
`endif
  output logic                        busy
);

  clkdiv_state_t    state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] pend_half_q, pend_half_d;
  logic             cfg_err_q, cfg_err_d;

  logic             acc, acc_ok, park, fall_ev;
  logic             en, load, last;
  logic [CNT_W-1:0] load_half;

  assign cfg_ready = (state_q != PEND) & ~reset;
  assign acc       = cfg_valid & cfg_ready;
  assign acc_ok    = acc & (cfg_half != '0);

  always_comb begin
    state_d     = state_q;
    pend_d      = pend_q;
    pend_half_d = pend_half_q;
    cfg_err_d   = acc & (cfg_half == '0);
    en          = 1'b0;
    load        = 1'b0;
    load_half   = pend_half_q;
    park        = 1'b0;
    fall_ev     = 1'b0;
    if (state_q == STOP) begin
      if (acc_ok) begin
        load      = 1'b1;
        load_half = cfg_half;
      end
      if (run) state_d = RUN;
    end else begin
      park    = ~run & ~clk_out;
      en      = ~park;
      fall_ev = en & clk_out & last;
      if (park) begin
        // Clock is already low, so any queued value can land safely on the way to STOP.
        state_d = STOP;
        pend_d  = 1'b0;
        if (acc_ok) begin
          load      = 1'b1;
          load_half = cfg_half;
        end else if (pend_q) begin
          load = 1'b1;
        end
      end else if (fall_ev) begin
        if (pend_q) load = 1'b1;
        pend_d = 1'b0;
        // A value offered on the toggle itself waits for the next one, unless we are stopping.
        if (acc_ok) begin
          if (run) begin
            pend_d      = 1'b1;
            pend_half_d = cfg_half;
          end else begin
            load      = 1'b1;
            load_half = cfg_half;
          end
        end
        state_d = !run ? STOP : (pend_d ? PEND : RUN);
      end else begin
        if (acc_ok) begin
          pend_d      = 1'b1;
          pend_half_d = cfg_half;
        end
        state_d = !run ? STOPPING : (pend_d ? PEND : RUN);
      end
    end
  end

  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q     <= STOP;
      pend_q      <= 1'b0;
      pend_half_q <= CNT_W'(DEF_HALF);
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      pend_half_q <= pend_half_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  clk_div_core #(
    .CNT_W    (CNT_W),
    .DEF_HALF (DEF_HALF)
  ) u_core (
    .clk_in    (clk_in),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .load_half (load_half),
    .clk_out   (clk_out),
    .tick_rise (tick_rise),
    .tick_fall (tick_fall),
    .last      (last)
  );

  assign cfg_err = cfg_err_q;
  assign busy    = (state_q != STOP);

`ifdef CLKDIV_CNT_EN
  logic [CLKDIV_CNT_WIDTH-1:0] rise_cnt_q, rise_cnt_d;

  always_comb begin
    rise_cnt_d = rise_cnt_q;
    if (load)           rise_cnt_d = '0;
    else if (tick_rise) rise_cnt_d = rise_cnt_q + CLKDIV_CNT_WIDTH'(1);
  end

  always_ff @(posedge clk_in) begin
    if (reset) rise_cnt_q <= '0;
    else       rise_cnt_q <= rise_cnt_d;
  end

  assign rise_cnt = rise_cnt_q;
`endif

endmodule
